fft_input_loader: RTL and testbench

- Upstream neighbour of the radix-2 butterfly unit.
- Accepts a serial stream of packed complex samples, one frame of N samples at a time, and stores them at bit-reversed addresses.
- Then issues the first-stage operand pairs (A, B, W) to the butterfly over a valid/ready handshake.
- Single-buffered: input is stalled while a frame is being issued.

---
 rtl/fft_pkg.sv | 19 +
 rtl/fft_bitrev_addr.sv | 16 +
 rtl/fft_input_loader.sv | 96 +++++++++
 tb/tb_fft_input_loader.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT types, field widths and twiddle constants
package fft_pkg;

  typedef enum logic {
    LOAD  = 1'b0,
    ISSUE = 1'b1
  } loader_state_e;

  // Twiddle parts in the butterfly's fixed-point format (real, imaginary)
  localparam int W0_RE    = 7;
  localparam int W0_IM    = 0;
  localparam int W1_N4_RE = 0;
  localparam int W1_N4_IM = -7;

  function automatic int field_width(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/fft_bitrev_addr.sv
// rtl/fft_bitrev_addr.sv - reverses the LOG2N low bits of a sample index
module fft_bitrev_addr #(
  parameter int LOG2N = 2
) (
  input  logic [LOG2N-1:0] count,
  output logic [LOG2N-1:0] addr
);

  always_comb begin
    addr = '0;
    for (int i = 0; i < LOG2N; i++) begin
      addr[i] = count[LOG2N-1-i];
    end
  end

endmodule

// File: rtl/fft_input_loader.sv
// rtl/fft_input_loader.sv - bit-reversed frame capture and stage-0 pair issue
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int LOG2N = 2,
  localparam int IDXW = (LOG2N > 1) ? LOG2N - 1 : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             bf_valid,
  input  logic             bf_ready,
  output logic [WIDTH-1:0] bf_a,
  output logic [WIDTH-1:0] bf_b,
  output logic [WIDTH-1:0] bf_w,
  output logic [IDXW-1:0]  bf_idx,
  output logic             frame_done
);

  localparam int HALF = field_width(WIDTH);
  localparam logic [WIDTH-1:0] W0 = {HALF'(W0_RE), HALF'(W0_IM)};

  loader_state_e    state;
  logic [LOG2N-1:0] count;
  logic [LOG2N-1:0] wr_addr;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] mem [N];
  logic [LOG2N-1:0] addr_a;
  logic [LOG2N-1:0] addr_b;
  logic             accept;

  fft_bitrev_addr #(.LOG2N(LOG2N)) u_bitrev (
    .count (count),
    .addr  (wr_addr)
  );

  assign in_ready = (state == LOAD) && !rst;
  assign accept   = in_valid && in_ready;

  // Pair k of stage 0 lives at adjacent addresses once the frame is bit-reversed
  assign addr_a = LOG2N'({idx, 1'b0});
  assign addr_b = addr_a | LOG2N'(1);

  assign bf_a   = mem[addr_a];
  assign bf_b   = mem[addr_b];
  assign bf_w   = W0;
  assign bf_idx = idx;

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_addr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      count      <= '0;
      idx        <= '0;
      bf_valid   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        LOAD: begin
          if (accept) begin
            count <= count + LOG2N'(1);
            if (count == LOG2N'(N - 1)) begin
              state    <= ISSUE;
              idx      <= '0;
              bf_valid <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (bf_ready) begin
            if (idx == IDXW'(N / 2 - 1)) begin
              state      <= LOAD;
              idx        <= '0;
              bf_valid   <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              idx <= idx + IDXW'(1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// tb/tb_fft_input_loader.sv - randomized and directed checks of fft_input_loader
module tb_fft_input_loader;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int LOG2N = 2;
  localparam int IDXW  = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             bf_valid;
  logic             bf_ready = 1'b1;
  logic [WIDTH-1:0] bf_a;
  logic [WIDTH-1:0] bf_b;
  logic [WIDTH-1:0] bf_w;
  logic [IDXW-1:0]  bf_idx;
  logic             frame_done;

  fft_input_loader #(.WIDTH(WIDTH), .N(N), .LOG2N(LOG2N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .bf_valid   (bf_valid),
    .bf_ready   (bf_ready),
    .bf_a       (bf_a),
    .bf_b       (bf_b),
    .bf_w       (bf_w),
    .bf_idx     (bf_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of samples; pairs come from bit-reversed placement
  bit              chk_en = 0;
  bit              m_issuing = 0;
  bit              m_done = 0;
  int              m_pidx = 0;
  logic [WIDTH-1:0] m_samples[$];
  logic [WIDTH-1:0] m_a [N/2];
  logic [WIDTH-1:0] m_b [N/2];

  function automatic int brev(input int v);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) if (v[i]) r |= 1 << (LOG2N - 1 - i);
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_issuing = 0;
      m_done    = 0;
      m_pidx    = 0;
      m_samples.delete();
      chk_en    = 1;
    end else begin
      m_done = 0;
      if (!m_issuing) begin
        if (in_valid) begin
          m_samples.push_back(in_data);
          if (m_samples.size() == N) begin
            logic [WIDTH-1:0] st [N];
            for (int i = 0; i < N; i++) st[brev(i)] = m_samples[i];
            for (int k = 0; k < N/2; k++) begin
              m_a[k] = st[2*k];
              m_b[k] = st[2*k+1];
            end
            m_samples.delete();
            m_issuing = 1;
            m_pidx    = 0;
          end
        end
      end else if (bf_ready) begin
        if (m_pidx == N/2 - 1) begin
          m_issuing = 0;
          m_done    = 1;
        end else begin
          m_pidx++;
        end
      end
    end
  end

  logic [WIDTH-1:0] log_a[$];
  logic [WIDTH-1:0] log_b[$];
  int               done_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("in_ready", int'(in_ready), int'(!m_issuing && !rst));
      check("bf_valid", int'(bf_valid), int'(m_issuing));
      check("frame_done", int'(frame_done), int'(m_done));
      if (m_issuing) begin
        check("bf_a", int'(bf_a), int'(m_a[m_pidx]));
        check("bf_b", int'(bf_b), int'(m_b[m_pidx]));
        check("bf_w", int'(bf_w), 'h70);
        check("bf_idx", int'(bf_idx), m_pidx);
      end
      if (bf_valid && bf_ready && !rst) begin
        log_a.push_back(bf_a);
        log_b.push_back(bf_b);
      end
      if (frame_done) done_cnt++;
    end
  end

  bit rdy_rand = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_rand) bf_ready = 1'($urandom_range(0, 1));
  end

  task automatic push_sample(input logic [WIDTH-1:0] d, input int gap);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) check("push_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done();
    int t = 0;
    @(negedge clk);
    while (!frame_done && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) check("done_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_a.delete();
    log_b.delete();
    done_cnt = 0;
  endtask

  task automatic check_pair(input string name, input int k, input int ea, input int eb);
    check({name, "_a"}, (k < log_a.size()) ? int'(log_a[k]) : -1, ea);
    check({name, "_b"}, (k < log_b.size()) ? int'(log_b[k]) : -1, eb);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_bf_valid", int'(bf_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic frame
    clear_log();
    push_sample(8'h10, 0); push_sample(8'h20, 0);
    push_sample(8'h30, 0); push_sample(8'h40, 0);
    @(negedge clk);
    check("basic_w", int'(bf_w), 'h70);
    wait_done();
    check_pair("basic_p0", 0, 'h10, 'h30);
    check_pair("basic_p1", 1, 'h20, 'h40);
    check("basic_done", done_cnt, 1);

    // Backpressure on pair 0
    clear_log();
    bf_ready = 1'b0;
    push_sample(8'h10, 0); push_sample(8'h20, 0);
    push_sample(8'h30, 0); push_sample(8'h40, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bf_ready = 1'b1;
    wait_done();
    check("bp_pairs", log_a.size(), 2);
    check_pair("bp_p0", 0, 'h10, 'h30);
    check_pair("bp_p1", 1, 'h20, 'h40);
    check("bp_done", done_cnt, 1);

    // Input stall with in_valid held during issue
    clear_log();
    push_sample(8'h10, 2); push_sample(8'h20, 1);
    push_sample(8'h30, 3); bf_ready = 1'b0; push_sample(8'h40, 0);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    bf_ready = 1'b1;
    wait_done();
    check_pair("stall_p0", 0, 'h10, 'h30);
    check_pair("stall_p1", 1, 'h20, 'h40);

    // Back-to-back frames
    clear_log();
    for (int i = 1; i <= 8; i++) push_sample(8'(i * 'h11), 0);
    wait_done();
    check_pair("b2b_p0", 0, 'h11, 'h33);
    check_pair("b2b_p1", 1, 'h22, 'h44);
    check_pair("b2b_p2", 2, 'h55, 'h77);
    check_pair("b2b_p3", 3, 'h66, 'h88);
    check("b2b_done", done_cnt, 2);

    // Reset mid-load
    clear_log();
    push_sample(8'h01, 0); push_sample(8'h02, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_sample(8'hA1, 0); push_sample(8'hB2, 0);
    push_sample(8'hC3, 0); push_sample(8'hD4, 0);
    wait_done();
    check_pair("rst_p0", 0, 'hA1, 'hC3);
    check_pair("rst_p1", 1, 'hB2, 'hD4);
    check("rst_done", done_cnt, 1);

    // Reset during issue with bf_ready low
    clear_log();
    bf_ready = 1'b0;
    push_sample(8'h5A, 0); push_sample(8'h6B, 0);
    push_sample(8'h7C, 0); push_sample(8'h8D, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_issue_valid", int'(bf_valid), 0);
    check("rst_issue_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    bf_ready = 1'b1;
    push_sample(8'h12, 0); push_sample(8'h34, 0);
    push_sample(8'h56, 0); push_sample(8'h78, 0);
    wait_done();
    check_pair("rst_issue_p0", 0, 'h12, 'h56);
    check_pair("rst_issue_p1", 1, 'h34, 'h78);
    check("rst_issue_done", done_cnt, 1);

    // Randomized frames with random gaps and backpressure
    clear_log();
    rdy_rand = 1;
    for (int f = 0; f < 25; f++) begin
      for (int s = 0; s < N; s++) push_sample(8'($urandom), $urandom_range(0, 2));
    end
    wait_done();
    rdy_rand = 0;
    bf_ready = 1'b1;
    check("rand_done", done_cnt, 25);
    check("rand_pairs", log_a.size(), 25 * N / 2);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
